tank_ctrl_gen: RTL and testbench

Parametrised player-tank controller; the next generation of the per-tank application block. It owns the tank's grid position and facing, and generates its own move rate from `clk` instead of a separate slow clock. It checks hits against N enemy bullets with valid qualifiers, tracks lives with a respawn delay, and issues single-cycle shoot pulses to the bullet block. It sits between the button debouncers and the bullet engine / VGA renderer.

---
 rtl/tank_pkg.sv | 16 +
 rtl/tank_hit_detect.sv | 28 ++
 rtl/tank_ctrl_gen.sv | 171 +++++++++++++++++
 tb/tb_tank_ctrl_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared definitions for the tank controller family: facing codes and FSM states.
package tank_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'b00,
    ST_HIT     = 2'b01,
    ST_RESPAWN = 2'b10,
    ST_DEAD    = 2'b11
  } tank_fsm_e;

endpackage

// File: rtl/tank_hit_detect.sv
// Flags a hit when any valid bullet sits on the given tank cell.
// Purely combinational so the same block serves player and enemy tanks.
module tank_hit_detect #(
  parameter int N_BUL = 4,
  parameter int POS_W = 5
) (
  input  logic [N_BUL*POS_W-1:0] bul_x,
  input  logic [N_BUL*POS_W-1:0] bul_y,
  input  logic [N_BUL-1:0]       bul_vld,
  input  logic [POS_W-1:0]       x_pos,
  input  logic [POS_W-1:0]       y_pos,
  output logic                   hit
);

  logic [N_BUL-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUL; gi++) begin : g_cmp
      assign match[gi] = bul_vld[gi]
                         && (bul_x[gi*POS_W +: POS_W] == x_pos)
                         && (bul_y[gi*POS_W +: POS_W] == y_pos);
    end
  endgenerate

  assign hit = |match;

endmodule

// File: rtl/tank_ctrl_gen.sv
// Player tank controller: grid position/facing, internal move-rate divider,
// bullet hit detection, lives with respawn delay and edge-triggered shooting.
module tank_ctrl_gen
  import tank_pkg::*;
#(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 20,
  parameter int POS_W       = 5,
  parameter int N_BUL       = 4,
  parameter int LIVES       = 3,
  parameter int MOVE_DIV    = 12_500_000,
  parameter int RESPAWN_CYC = 25_000_000,
  parameter int START_X     = 8,
  parameter int START_Y     = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tank_en,
  input  logic                         bt_w,
  input  logic                         bt_a,
  input  logic                         bt_s,
  input  logic                         bt_d,
  input  logic                         bt_st,
  input  logic [N_BUL*POS_W-1:0]       bul_x,
  input  logic [N_BUL*POS_W-1:0]       bul_y,
  input  logic [N_BUL-1:0]             bul_vld,
  input  logic                         mybul_busy,
  output logic [POS_W-1:0]             x_pos,
  output logic [POS_W-1:0]             y_pos,
  output logic [1:0]                   tank_dir,
  output logic                         tank_state,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic                         game_over,
  output logic                         bul_sht
);

  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int MCNT_W  = $clog2(MOVE_DIV);
  localparam int RCNT_W  = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;

  localparam logic [POS_W-1:0]   START_XV = POS_W'(START_X);
  localparam logic [POS_W-1:0]   START_YV = POS_W'(START_Y);
  localparam logic [POS_W-1:0]   X_MAX    = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0]   Y_MAX    = POS_W'(GRID_H - 1);
  localparam logic [MCNT_W-1:0]  MCNT_MAX = MCNT_W'(MOVE_DIV - 1);
  localparam logic [RCNT_W-1:0]  RCNT_MAX = RCNT_W'(RESPAWN_CYC - 1);

  tank_fsm_e           state_reg, state_next;
  logic [POS_W-1:0]    x_reg, y_reg;
  logic [1:0]          dir_reg;
  logic [LIVES_W-1:0]  lives_reg;
  logic [MCNT_W-1:0]   mcnt_reg;
  logic [RCNT_W-1:0]   rcnt_reg;
  logic                st_prev_reg;
  logic                sht_reg;

  logic                hit;
  logic                alive;
  logic                run;
  logic                step;
  logic                resp_done;
  logic [POS_W-1:0]    x_next, y_next;
  logic [1:0]          dir_next;

  tank_hit_detect #(
    .N_BUL (N_BUL),
    .POS_W (POS_W)
  ) u_hit (
    .bul_x   (bul_x),
    .bul_y   (bul_y),
    .bul_vld (bul_vld),
    .x_pos   (x_reg),
    .y_pos   (y_reg),
    .hit     (hit)
  );

  // A hit in ALIVE pre-empts both a move step and a shoot in the same cycle.
  assign alive     = (state_reg == ST_ALIVE);
  assign run       = alive && tank_en && !hit;
  assign step      = run && (mcnt_reg == MCNT_MAX);
  assign resp_done = (state_reg == ST_RESPAWN) && (rcnt_reg == RCNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ALIVE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ALIVE:   if (hit) state_next = ST_HIT;
      ST_HIT:     state_next = (lives_reg == LIVES_W'(1)) ? ST_DEAD : ST_RESPAWN;
      ST_RESPAWN: if (resp_done) state_next = ST_ALIVE;
      default:    state_next = ST_DEAD;
    endcase
  end

  // Button priority w > s > a > d; facing updates even when clamped at an edge.
  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    dir_next = dir_reg;
    if (bt_w) begin
      dir_next = DIR_UP;
      if (y_reg != '0) y_next = y_reg - POS_W'(1);
    end else if (bt_s) begin
      dir_next = DIR_DOWN;
      if (y_reg != Y_MAX) y_next = y_reg + POS_W'(1);
    end else if (bt_a) begin
      dir_next = DIR_LEFT;
      if (x_reg != '0) x_next = x_reg - POS_W'(1);
    end else if (bt_d) begin
      dir_next = DIR_RIGHT;
      if (x_reg != X_MAX) x_next = x_reg + POS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg       <= START_XV;
      y_reg       <= START_YV;
      dir_reg     <= DIR_UP;
      lives_reg   <= LIVES_W'(LIVES);
      mcnt_reg    <= '0;
      rcnt_reg    <= '0;
      st_prev_reg <= 1'b0;
      sht_reg     <= 1'b0;
    end else begin
      st_prev_reg <= bt_st;
      sht_reg     <= run && !mybul_busy && bt_st && !st_prev_reg;

      if (state_reg == ST_HIT) begin
        lives_reg <= lives_reg - LIVES_W'(1);
      end

      if (state_reg == ST_RESPAWN) begin
        rcnt_reg <= rcnt_reg + RCNT_W'(1);
      end else begin
        rcnt_reg <= '0;
      end

      if (resp_done) begin
        x_reg    <= START_XV;
        y_reg    <= START_YV;
        dir_reg  <= DIR_UP;
        mcnt_reg <= '0;
      end else if (run) begin
        mcnt_reg <= (mcnt_reg == MCNT_MAX) ? '0 : mcnt_reg + MCNT_W'(1);
        if (step) begin
          x_reg   <= x_next;
          y_reg   <= y_next;
          dir_reg <= dir_next;
        end
      end
    end
  end

  always_comb begin
    x_pos      = x_reg;
    y_pos      = y_reg;
    tank_dir   = dir_reg;
    lives      = lives_reg;
    tank_state = (state_reg == ST_ALIVE);
    game_over  = (state_reg == ST_DEAD);
    bul_sht    = sht_reg;
  end

endmodule

// File: tb/tb_tank_ctrl_gen.sv
// Randomized bench for tank_ctrl_gen against a cycle-level behavioural model.
module tb_tank_ctrl_gen;

  localparam int GRID_W      = 16;
  localparam int GRID_H      = 20;
  localparam int POS_W       = 5;
  localparam int N_BUL       = 4;
  localparam int LIVES       = 3;
  localparam int MOVE_DIV    = 4;
  localparam int RESPAWN_CYC = 8;
  localparam int START_X     = 8;
  localparam int START_Y     = 18;
  localparam int N_CYC       = 4000;

  localparam int M_ALIVE = 0, M_HIT = 1, M_RESPAWN = 2, M_DEAD = 3;

  logic clk = 1'b0;
  logic rst, tank_en, bt_w, bt_a, bt_s, bt_d, bt_st, mybul_busy;
  logic [N_BUL*POS_W-1:0] bul_x, bul_y;
  logic [N_BUL-1:0]       bul_vld;
  logic [POS_W-1:0]       x_pos, y_pos;
  logic [1:0]             tank_dir;
  logic                   tank_state, game_over, bul_sht;
  logic [$clog2(LIVES+1)-1:0] lives;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  int  m_mode = M_ALIVE;
  int  m_x = START_X, m_y = START_Y, m_dir = 0, m_lives = LIVES;
  int  m_tick = 0, m_wait = 0;
  bit  m_st_prev = 0, m_sht = 0;

  always #5 clk = ~clk;

  tank_ctrl_gen #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .POS_W(POS_W), .N_BUL(N_BUL),
    .LIVES(LIVES), .MOVE_DIV(MOVE_DIV), .RESPAWN_CYC(RESPAWN_CYC),
    .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .clk(clk), .rst(rst), .tank_en(tank_en),
    .bt_w(bt_w), .bt_a(bt_a), .bt_s(bt_s), .bt_d(bt_d), .bt_st(bt_st),
    .bul_x(bul_x), .bul_y(bul_y), .bul_vld(bul_vld), .mybul_busy(mybul_busy),
    .x_pos(x_pos), .y_pos(y_pos), .tank_dir(tank_dir), .tank_state(tank_state),
    .lives(lives), .game_over(game_over), .bul_sht(bul_sht)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_ALIVE; m_x = START_X; m_y = START_Y; m_dir = 0;
    m_lives = LIVES; m_tick = 0; m_wait = 0; m_st_prev = 0; m_sht = 0;
  endtask

  // One clock of the game rules, applied to the inputs the DUT just sampled.
  task automatic model_step();
    bit hit;
    hit = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == M_ALIVE)
      for (int i = 0; i < N_BUL; i++)
        if (bul_vld[i] && bul_x[i*POS_W +: POS_W] == m_x && bul_y[i*POS_W +: POS_W] == m_y)
          hit = 1;
    m_sht = (m_mode == M_ALIVE) && tank_en && !mybul_busy && bt_st && !m_st_prev && !hit;
    m_st_prev = bt_st;
    case (m_mode)
      M_ALIVE: begin
        if (hit) m_mode = M_HIT;
        else if (tank_en) begin
          if (m_tick == MOVE_DIV - 1) begin
            m_tick = 0;
            if (bt_w)      begin m_dir = 0; if (m_y > 0) m_y--; end
            else if (bt_s) begin m_dir = 1; if (m_y < GRID_H - 1) m_y++; end
            else if (bt_a) begin m_dir = 2; if (m_x > 0) m_x--; end
            else if (bt_d) begin m_dir = 3; if (m_x < GRID_W - 1) m_x++; end
          end else m_tick++;
        end
      end
      M_HIT: begin
        m_lives--;
        m_mode = (m_lives == 0) ? M_DEAD : M_RESPAWN;
        m_wait = 0;
      end
      M_RESPAWN: begin
        m_wait++;
        if (m_wait == RESPAWN_CYC) begin
          m_mode = M_ALIVE; m_x = START_X; m_y = START_Y; m_dir = 0; m_tick = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("x_pos", x_pos, m_x);
    check("y_pos", y_pos, m_y);
    check("tank_dir", tank_dir, m_dir);
    check("tank_state", tank_state, m_mode == M_ALIVE);
    check("lives", lives, m_lives);
    check("game_over", game_over, m_mode == M_DEAD);
    check("bul_sht", bul_sht, m_sht);
  endtask

  initial begin
    int seg_left, seg_id;
    logic [3:0] seg_btn;
    logic seg_en;
    seg_left = 0; seg_id = 0; seg_btn = 4'b0; seg_en = 1'b1;
    rst = 1'b1; tank_en = 1'b0; bt_w = 0; bt_a = 0; bt_s = 0; bt_d = 0;
    bt_st = 0; mybul_busy = 0; bul_x = '0; bul_y = '0; bul_vld = '0;
    @(posedge clk); model_step();

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      compare_all();

      // Directed opening: hold w to the top edge, then d into the right wall.
      if (cyc < 2) begin
        rst = 1'b1;
      end else if (cyc < 102) begin
        rst = 1'b0; tank_en = 1'b1; {bt_w, bt_s, bt_a, bt_d} = 4'b1000;
        if (cyc == 2) $display("seg %0d: directed hold w", seg_id++);
      end else if (cyc < 162) begin
        {bt_w, bt_s, bt_a, bt_d} = 4'b0001;
        if (cyc == 102) $display("seg %0d: directed hold d", seg_id++);
      end else begin
        if (seg_left == 0) begin
          seg_left = $urandom_range(8, 60);
          seg_btn  = 4'($urandom_range(0, 15));
          seg_en   = ($urandom_range(0, 4) != 0);
          $display("seg %0d: btn(wsad)=%b en=%b len=%0d", seg_id++, seg_btn, seg_en, seg_left);
        end
        seg_left--;
        {bt_w, bt_s, bt_a, bt_d} = seg_btn;
        tank_en = seg_en;
        rst = ($urandom_range(0, 299) == 0);
      end

      if ($urandom_range(0, 5) == 0) bt_st = ~bt_st;
      mybul_busy = ($urandom_range(0, 3) == 0);

      bul_vld = '0;
      for (int i = 0; i < N_BUL; i++) begin
        bul_x[i*POS_W +: POS_W] = POS_W'($urandom_range(0, GRID_W - 1));
        bul_y[i*POS_W +: POS_W] = POS_W'($urandom_range(0, GRID_H - 1));
        bul_vld[i] = ($urandom_range(0, 1) == 1);
      end
      if (cyc >= 162 && $urandom_range(0, 24) == 0) begin
        int k;
        k = $urandom_range(0, N_BUL - 1);
        bul_x[k*POS_W +: POS_W] = POS_W'(m_x);
        bul_y[k*POS_W +: POS_W] = POS_W'(m_y);
        bul_vld[k] = ($urandom_range(0, 2) != 0);
      end

      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    compare_all();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
